serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serial frame transmitter that produces the single-wire framed stream consumed by the team's serial port-demultiplexer receiver. Given a 2-bit destination port, a 4-bit payload length N and up to 15 payload bits, it serialises the frame as follows:

- one start bit (0);
- the port number, MSB first;
- the length, MSB first;
- N payload bits.

Bit advance is paced by a one-cycle enable tick, such as the one-pulser output, so the same push-button or tick source drives both ends of the link.

## Interface
- MAX_LEN, 15: payload buffer width; equals the largest value of the 4-bit length field.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- bit_en  input  1  one-cycle bit-period tick; the line advances one bit per tick.
- start  input  1  request to send a frame; sampled only while ready=1.
- port_in  input  2  destination port number.
- len_in  input  4  payload length N, range 0..15.
- data_in  input  MAX_LEN  payload; data_in[0] is sent first, then data_in[1], up to data_in[N-1].
- SerOut  output  1  serial line; idles high.
- ready  output  1  high in IDLE; a frame may be requested.
- tx_valid  output  1  high while a payload bit is on SerOut.
- Done  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, START, PORT, LEN, DATA.
- IDLE
  - Outputs: SerOut=1, ready=1.
  - If start=1: capture port_in, len_in and data_in into internal registers, then go to START.
  - Input changes after capture have no effect on the frame in flight.
- START
  - SerOut=0.
  - On bit_en: go to PORT with bit index 1.
- PORT
  - SerOut = port_reg[idx].
  - On bit_en: idx 1→0; after idx 0, go to LEN with idx 3.
- LEN
  - SerOut = len_reg[idx].
  - On bit_en: idx decrements; after idx 0:
    - if len_reg=0: go to IDLE and pulse Done;
    - else: go to DATA, load the down-counter with len_reg and set the data pointer to 0.
- DATA
  - SerOut = data_reg[ptr], tx_valid=1.
  - On bit_en: ptr increments and the counter decrements.
  - When the counter reaches 0, on that same edge: go to IDLE and pulse Done.
- SerOut, tx_valid and ready are registered outputs, with no combinational path from inputs.
- Done is high for exactly one clk cycle, in the cycle after the final bit_en edge. SerOut=1 and ready=1 in that same cycle.
- Arithmetic
  - The counter is 4 bits and counts down only; it never wraps, because exit happens at 1→0.
  - The pointer is 4 bits and never exceeds N-1.
- Boundary conditions
  - start while busy (ready=0): ignored; the frame in flight is unaffected.
  - start and bit_en in the same IDLE cycle: the start is accepted; that bit_en does not shorten the start bit.
  - bit_en held high for several cycles: each high cycle is one tick. The upstream one-pulser is responsible for single ticks.
  - Back-to-back frames: start asserted in the Done cycle is accepted. The line gives at least one clk of idle-high before the next start bit.
  - Reset mid-frame (rst=0 at any edge): IDLE, SerOut=1, tx_valid=0, Done=0, ready=1 from the next cycle; the partial frame is abandoned.
  - Payload bits data_in[MAX_LEN-1:N] are never transmitted.

## Timing
- Reset values: SerOut=1, ready=1, tx_valid=0, Done=0; state IDLE; all counters 0.
- Start latency:
  - start accepted at edge t;
  - SerOut=0 and ready=0 from t+1;
  - the start bit lasts until the first bit_en edge at or after t+1.
- Bit period: each subsequent bit occupies the interval between consecutive bit_en edges.
- Frame length in bit_en ticks: 1 + 2 + 4 + N = 7 + N.
- Done is asserted in the cycle following the (7+N)-th bit_en tick after acceptance.
- tx_valid rises with the first payload bit and falls on the edge that raises Done.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 and bit_en toggling → SerOut=1, ready=1, tx_valid=0, Done=0 throughout; no frame starts.
- Nominal frame: port_in=2'b10, len_in=4'b0011, data_in[2:0]=3'b101, bit_en every 4 clk cycles.
  - SerOut sequence per tick: 0, 1,0, 0,0,1,1, 1,0,1.
  - tx_valid high for exactly 3 bit periods.
  - Done pulses once after tick 10; ready returns to 1.
- Zero length: port_in=2'b01, len_in=0.
  - SerOut sequence: 0, 0,1, 0,0,0,0.
  - tx_valid never rises; Done after tick 7.
- Max length: len_in=4'hF, data_in=15'h5AC3.
  - 22 ticks total.
  - The 15 payload bits match data_in[0..14] in order (1,1,0,0,0,0,1,1,0,1,0,1,1,0,1).
  - Done after tick 22.
- Ignore and back-to-back:
  - start pulsed mid-payload → the frame is unchanged.
  - start held through the Done cycle → second frame starts; SerOut high for ≥1 cycle between frames.
  - start and bit_en coincident in IDLE → full-length start bit.
- Reset mid-frame: rst=0 during the LEN field → next cycle SerOut=1, ready=1, tx_valid=0, no Done; the next start sends a complete correct frame.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length (MSB first),
// then N payload bits (LSB first), one bit per bit_en tick.
module serial_frame_tx #(
  parameter int unsigned MAX_LEN = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_en,
  input  logic               start,
  input  logic [1:0]         port_in,
  input  logic [3:0]         len_in,
  input  logic [MAX_LEN-1:0] data_in,
  output logic               SerOut,
  output logic               ready,
  output logic               tx_valid,
  output logic               Done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    LEN,
    DATA
  } state_t;

  state_t             state;
  logic [1:0]         port_reg;
  logic [3:0]         len_reg;
  logic [MAX_LEN-1:0] data_reg;
  logic [1:0]         idx;
  logic [3:0]         cnt;
  logic [3:0]         ptr;

  // Each transition loads SerOut with the bit that the new state presents,
  // so the line is fully registered and changes only on the advancing edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      port_reg <= '0;
      len_reg  <= '0;
      data_reg <= '0;
      idx      <= '0;
      cnt      <= '0;
      ptr      <= '0;
      SerOut   <= 1'b1;
      ready    <= 1'b1;
      tx_valid <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          SerOut   <= 1'b1;
          ready    <= 1'b1;
          tx_valid <= 1'b0;
          if (start) begin
            port_reg <= port_in;
            len_reg  <= len_in;
            data_reg <= data_in;
            state    <= START;
            SerOut   <= 1'b0;
            ready    <= 1'b0;
          end
        end
        START: begin
          if (bit_en) begin
            state  <= PORT;
            idx    <= 2'd1;
            SerOut <= port_reg[1];
          end
        end
        PORT: begin
          if (bit_en) begin
            if (idx == 2'd0) begin
              state  <= LEN;
              idx    <= 2'd3;
              SerOut <= len_reg[3];
            end else begin
              idx    <= idx - 2'd1;
              SerOut <= port_reg[0];
            end
          end
        end
        LEN: begin
          if (bit_en) begin
            if (idx == 2'd0) begin
              if (len_reg == 4'd0) begin
                state  <= IDLE;
                Done   <= 1'b1;
                SerOut <= 1'b1;
                ready  <= 1'b1;
              end else begin
                state    <= DATA;
                cnt      <= len_reg;
                ptr      <= 4'd0;
                SerOut   <= data_reg[0];
                tx_valid <= 1'b1;
              end
            end else begin
              idx    <= idx - 2'd1;
              SerOut <= len_reg[idx - 2'd1];
            end
          end
        end
        DATA: begin
          if (bit_en) begin
            if (cnt == 4'd1) begin
              state    <= IDLE;
              cnt      <= 4'd0;
              Done     <= 1'b1;
              SerOut   <= 1'b1;
              ready    <= 1'b1;
              tx_valid <= 1'b0;
            end else begin
              cnt    <= cnt - 4'd1;
              ptr    <= ptr + 4'd1;
              SerOut <= data_reg[ptr + 4'd1];
            end
          end
        end
        default: begin
          state    <= IDLE;
          SerOut   <= 1'b1;
          ready    <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: table of frames with hand-computed bit
// sequences, plus reset, back-to-back and mid-frame reset sequences.
module tb_serial_frame_tx;

  logic        clk;
  logic        rst;
  logic        bit_en;
  logic        start;
  logic [1:0]  port_in;
  logic [3:0]  len_in;
  logic [14:0] data_in;
  logic        SerOut;
  logic        ready;
  logic        tx_valid;
  logic        Done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  serial_frame_tx #(.MAX_LEN(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_en   (bit_en),
    .start    (start),
    .port_in  (port_in),
    .len_in   (len_in),
    .data_in  (data_in),
    .SerOut   (SerOut),
    .ready    (ready),
    .tx_valid (tx_valid),
    .Done     (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seq holds the transmitted bits in send order starting at bit 21
  typedef struct {
    logic [1:0]  port;
    logic [3:0]  len;
    logic [14:0] data;
    int unsigned gap;
    bit          coinc;
    int          poke;
    logic [21:0] seq;
    int unsigned ticks;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_serout"}, 32'(SerOut), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_txvalid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  // Request a frame at a negedge; inputs are scrambled right after capture.
  task automatic launch(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                        input bit coinc);
    port_in = p;
    len_in  = l;
    data_in = d;
    start   = 1'b1;
    bit_en  = coinc;
    @(negedge clk);
    start   = 1'b0;
    bit_en  = 1'b0;
    port_in = ~p;
    len_in  = ~l;
    data_in = ~d;
  endtask

  // Walk the frame bit by bit; on return (full=1) we are in the Done cycle.
  task automatic body(input logic [21:0] seq, input int unsigned ticks, input int unsigned gap,
                      input int poke, input bit full);
    for (int unsigned k = 0; k < ticks; k++) begin
      for (int unsigned g = 0; g < gap; g++) begin
        chk("serout", 32'(SerOut), 32'(seq[21-k]));
        chk("tx_valid", 32'(tx_valid), 32'(k >= 7));
        chk("ready_busy", 32'(ready), 32'd0);
        chk("done_busy", 32'(Done), 32'd0);
        if (poke >= 0 && k == poke && g == 0) start = 1'b1;
        if (g == gap - 1) bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        start  = 1'b0;
      end
    end
    if (full) begin
      chk("done_pulse", 32'(Done), 32'd1);
      chk("done_serout", 32'(SerOut), 32'd1);
      chk("done_ready", 32'(ready), 32'd1);
      chk("done_txvalid", 32'(tx_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{port: 2'b10, len: 4'd3,  data: 15'b000000000000101, gap: 4, coinc: 1'b0,
                poke: -1, seq: 22'b0100011101_000000000000, ticks: 10};
    vecs[1] = '{port: 2'b01, len: 4'd0,  data: 15'h7FFF, gap: 2, coinc: 1'b1,
                poke: -1, seq: 22'b0010000_000000000000000, ticks: 7};
    vecs[2] = '{port: 2'b11, len: 4'hF,  data: 15'h5AC3, gap: 1, coinc: 1'b0,
                poke: -1, seq: 22'b0111111110000110101101, ticks: 22};
    vecs[3] = '{port: 2'b00, len: 4'd1,  data: 15'h7FFE, gap: 3, coinc: 1'b0,
                poke: 7, seq: 22'b00000010_00000000000000, ticks: 8};
    vecs[4] = '{port: 2'b01, len: 4'd5,  data: 15'h7FF6, gap: 2, coinc: 1'b1,
                poke: 9, seq: 22'b001010101101_0000000000, ticks: 12};

    rst = 1'b0; bit_en = 1'b0; start = 1'b1;
    port_in = 2'b11; len_in = 4'd5; data_in = 15'h1234;

    // Reset held with start asserted and bit_en toggling
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk("reset");
      bit_en = ~bit_en;
    end
    rst = 1'b1; start = 1'b0; bit_en = 1'b0;
    @(negedge clk);
    idle_chk("post_reset");

    for (int unsigned v = 0; v < 5; v++) begin
      launch(vecs[v].port, vecs[v].len, vecs[v].data, vecs[v].coinc);
      body(vecs[v].seq, vecs[v].ticks, vecs[v].gap, vecs[v].poke, 1'b1);
      @(negedge clk);
      idle_chk("after_frame");
    end

    // Back-to-back: start asserted in the Done cycle of the first frame
    launch(vecs[1].port, vecs[1].len, vecs[1].data, 1'b0);
    body(vecs[1].seq, vecs[1].ticks, 2, -1, 1'b1);
    launch(vecs[0].port, vecs[0].len, vecs[0].data, 1'b0);
    body(vecs[0].seq, vecs[0].ticks, 2, -1, 1'b1);
    @(negedge clk);
    idle_chk("b2b_end");

    // Reset during the LEN field abandons the frame
    launch(vecs[0].port, vecs[0].len, vecs[0].data, 1'b0);
    body(vecs[0].seq, 5, 2, -1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_chk("midreset");
    for (int unsigned i = 0; i < 12; i++) begin
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      idle_chk("midreset_quiet");
    end
    launch(vecs[0].port, vecs[0].len, vecs[0].data, 1'b0);
    body(vecs[0].seq, vecs[0].ticks, 3, -1, 1'b1);
    @(negedge clk);
    idle_chk("recovered");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
